// File: rtl/dm_sba_pkg.sv
// Shared types and defaults for the debug-side memory burst reader.
// The range-check behaviour is selected by the DM_SBA_RANGE_CHECK_EN macro
// inside dm_mem_burst_reader; nothing in this package depends on it.
package dm_sba_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } sba_state_e;

    localparam int unsigned DM_MEM_WORDS = 32;
    localparam int unsigned DM_LEN_W     = 5;

    // One response beat as seen on the response channel.
    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } sba_rsp_t;

endpackage

// File: rtl/dm_mem_burst_reader.sv
// Debug memory burst reader: turns single/multi-word read commands into
// one-cycle debug read strobes on the data memory and returns each captured
// word over a valid/ready response channel.
//
// Build option DM_SBA_RANGE_CHECK_EN:
//   defined   - addresses >= MEM_WORDS are never driven to memory; they
//               produce a single error word (data 0, err 1, last 1) that
//               terminates the burst.
//   undefined - the driven address wraps modulo MEM_WORDS, rsp_err_o is 0
//               and bursts always run to their full length.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready_o high unless abort_i
// READ  | one-cycle debug read strobe; memory word captured at the edge
// RESP  | response word presented, held until rsp_ready_i
module dm_mem_burst_reader
    import dm_sba_pkg::*;
#(
    parameter int unsigned MEM_WORDS = DM_MEM_WORDS,
    parameter int unsigned LEN_W     = DM_LEN_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [31:0]      cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             cmd_autoinc_i,
    input  logic             abort_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_data_o,
    output logic             rsp_last_o,
    output logic             rsp_err_o,
    output logic             dm_Mem_rd_en_o,
    output logic [31:0]      dm_Mem_rd_address_o,
    input  logic [31:0]      dm_Mem_rd_wr_data_i,
    output logic             busy_o
);

    // Word-address mask; MEM_WORDS is a power of two so this is the wrap.
    localparam logic [31:0] ADDR_MASK = 32'(MEM_WORDS - 1);

    sba_state_e       state_q;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] remaining_q;
    logic             autoinc_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_data_q;
    logic             rsp_last_q;
    logic             rd_en_q;
    logic [31:0]      rd_address_q;

    logic [31:0]      addr_inc;
    logic             cmd_addr_ok;
    logic             next_addr_ok;

    // Address of the following word in the burst (32-bit, no saturation).
    assign addr_inc = addr_q + {31'd0, autoinc_q};

`ifdef DM_SBA_RANGE_CHECK_EN
    logic rsp_err_q;

    // Only in-range addresses may ever reach the memory's read port.
    assign cmd_addr_ok  = (cmd_addr_i < 32'(MEM_WORDS));
    assign next_addr_ok = (addr_inc   < 32'(MEM_WORDS));
    assign rsp_err_o    = rsp_err_q;
`else
    // Without range checking every address is folded into the memory.
    assign cmd_addr_ok  = 1'b1;
    assign next_addr_ok = 1'b1;
    assign rsp_err_o    = 1'b0;
`endif

    // Handshake and status outputs derived from the current state.
    assign cmd_ready_o         = (state_q == IDLE) && !abort_i;
    assign busy_o              = (state_q != IDLE);
    assign rsp_valid_o         = rsp_valid_q;
    assign rsp_data_o          = rsp_data_q;
    assign rsp_last_o          = rsp_last_q;
    assign dm_Mem_rd_en_o      = rd_en_q;
    assign dm_Mem_rd_address_o = rd_address_q;

    // Sequencer FSM with registered strobe/address and response registers.
    // The read strobe is set on the transition into READ so it is high for
    // exactly the READ cycle and low everywhere else.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            autoinc_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_last_q   <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_address_q <= '0;
`ifdef DM_SBA_RANGE_CHECK_EN
            rsp_err_q    <= 1'b0;
`endif
        end else if (abort_i) begin
            // Abort wins over any handshake or new command; the pending
            // word is dropped.
            state_q      <= IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_last_q   <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_address_q <= '0;
`ifdef DM_SBA_RANGE_CHECK_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q       <= cmd_addr_i;
                        remaining_q  <= cmd_len_i;
                        autoinc_q    <= cmd_autoinc_i;
                        rd_en_q      <= cmd_addr_ok;
                        rd_address_q <= cmd_addr_ok ? (cmd_addr_i & ADDR_MASK) : '0;
                        state_q      <= READ;
                    end
                end

                READ: begin
                    rd_en_q      <= 1'b0;
                    rd_address_q <= '0;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                    if (rd_en_q) begin
                        rsp_data_q <= dm_Mem_rd_wr_data_i;
                        rsp_last_q <= (remaining_q == '0);
`ifdef DM_SBA_RANGE_CHECK_EN
                        rsp_err_q  <= 1'b0;
`endif
                    end else begin
                        // Out-of-range word: bus was never enabled, so the
                        // data is forced to zero and the burst ends here.
                        rsp_data_q <= '0;
                        rsp_last_q <= 1'b1;
`ifdef DM_SBA_RANGE_CHECK_EN
                        rsp_err_q  <= 1'b1;
`endif
                    end
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        if (rsp_last_q) begin
                            state_q <= IDLE;
                        end else begin
                            remaining_q  <= remaining_q - LEN_W'(1);
                            addr_q       <= addr_inc;
                            rd_en_q      <= next_addr_ok;
                            rd_address_q <= next_addr_ok ? (addr_inc & ADDR_MASK) : '0;
                            state_q      <= READ;
                        end
                    end
                end

                default: begin
                    state_q      <= IDLE;
                    rsp_valid_q  <= 1'b0;
                    rd_en_q      <= 1'b0;
                    rd_address_q <= '0;
                end
            endcase
        end
    end

endmodule
